// File: rtl/spec_load_gate.sv
// In-order load queue that holds speculative loads until the fetch fence
// grants permission, then issues them to the LSU one head entry at a time.
module spec_load_gate #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int TAG_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     allow_load_i,
  input  logic                     flush_i,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [ADDR_W-1:0]        ld_addr_i,
  input  logic [TAG_W-1:0]         ld_tag_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [ADDR_W-1:0]        issue_addr_o,
  output logic [TAG_W-1:0]         issue_tag_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     blocked_o,
  output logic [31:0]              stall_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [TAG_W-1:0]  tag_mem_q  [DEPTH];

  logic [PTR_W-1:0]  occ;
  logic              empty;
  logic              full;
  logic              enq;
  logic              deq;

  // Pointer difference modulo 2^PTR_W; the extra MSB separates full from empty.
  assign occ   = wr_ptr_q - rd_ptr_q;
  assign empty = (occ == '0);
  assign full  = (occ == PTR_W'(DEPTH));

  // rst_n gates ready so the queue refuses requests while held in reset.
  assign ld_ready_o    = rst_n && !full && !flush_i;
  assign issue_valid_o = !empty && allow_load_i && !flush_i;
  assign blocked_o     = !empty && !allow_load_i;
  assign occupancy_o   = occ;
  assign stall_cnt_o   = stall_cnt_q;

  assign issue_addr_o = empty ? '0 : addr_mem_q[rd_ptr_q[IDX_W-1:0]];
  assign issue_tag_o  = empty ? '0 : tag_mem_q[rd_ptr_q[IDX_W-1:0]];

  assign enq = ld_valid_i && ld_ready_o && !flush_i;
  assign deq = issue_valid_o && issue_ready_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (blocked_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload storage needs no reset: entries outside rd..wr are never visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q[IDX_W-1:0]] <= ld_addr_i;
      tag_mem_q[wr_ptr_q[IDX_W-1:0]]  <= ld_tag_i;
    end
  end

endmodule

// File: doc/spec_load_gate.md
SPEC_LOAD_GATE -- requirements
Module: spec_load_gate

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of load-queue entries (a power of two, at least 2).
REQ-002 The block SHALL have parameter ADDR_W, default 64, meaning the load address width.
REQ-003 The block SHALL have parameter TAG_W, default 6, meaning the load ROB/LSQ tag width.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port allow_load_i  input  1  the load permission from the speculative fetch fence; 1 means no fences are pending.
REQ-007 The block SHALL have port flush_i  input  1  the pipeline flush that discards all queued loads.
REQ-008 The block SHALL have port ld_valid_i  input  1  an incoming load request is valid.
REQ-009 The block SHALL have port ld_ready_o  output  1  the queue can accept a load request.
REQ-010 The block SHALL have port ld_addr_i  input  ADDR_W  the incoming load address.
REQ-011 The block SHALL have port ld_tag_i  input  TAG_W  the incoming load tag.
REQ-012 The block SHALL have port issue_valid_o  output  1  a head load is presented to the LSU.
REQ-013 The block SHALL have port issue_ready_i  input  1  the LSU accepts the presented load.
REQ-014 The block SHALL have port issue_addr_o  output  ADDR_W  the head load address.
REQ-015 The block SHALL have port issue_tag_o  output  TAG_W  the head load tag.
REQ-016 The block SHALL have port occupancy_o  output  $clog2(DEPTH)+1  the number of valid queue entries.
REQ-017 The block SHALL have port blocked_o  output  1  the queue is non-empty and allow_load_i is 0.
REQ-018 The block SHALL have port stall_cnt_o  output  32  a saturating count of blocked cycles.

Function
REQ-019 The queue SHALL be an in-order FIFO of {addr, tag}, with rd/wr pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap-around.
REQ-020 Enqueue SHALL occur on a clock edge when ld_valid_i && ld_ready_o && !flush_i; there is no combinational bypass, so the minimum latency from ld_valid_i to issue_valid_o is 1 cycle.
REQ-021 ld_ready_o SHALL equal !full && !flush_i, where full means occupancy == DEPTH; a dequeue in the same cycle SHALL NOT make a full queue ready.
REQ-022 issue_valid_o SHALL equal !empty && allow_load_i && !flush_i (combinational gate); it MAY deassert before acceptance when allow_load_i falls, and the LSU SHALL NOT rely on its persistence.
REQ-023 issue_addr_o and issue_tag_o SHALL always reflect the head entry, and SHALL be 0 when the queue is empty.
REQ-024 Dequeue SHALL occur on a clock edge when issue_valid_o && issue_ready_i.
REQ-025 When enqueue and dequeue occur in the same cycle, both SHALL complete and occupancy SHALL be unchanged.
REQ-026 Loads SHALL issue strictly in enqueue order; a blocked head SHALL block all younger entries.
REQ-027 When flush_i = 1, the next edge SHALL set both pointers to 0 and occupancy to 0; any same-cycle enqueue or dequeue SHALL be suppressed.
REQ-028 blocked_o SHALL equal !empty && !allow_load_i.
REQ-029 stall_cnt_o SHALL increment by 1 on each edge where blocked_o = 1, and SHALL hold at 32'hFFFF_FFFF.
REQ-030 stall_cnt_o SHALL NOT be cleared by flush_i.
REQ-031 A ld_valid_i with ld_ready_o = 0 SHALL leave the queue unchanged; the requester holds the request.

Reset
REQ-032 While rst_n = 0, the block SHALL asynchronously set pointers, occupancy_o, and stall_cnt_o to 0, and all entries invalid.
REQ-033 During reset, the outputs SHALL be ld_ready_o = 0, issue_valid_o = 0, blocked_o = 0, and issue_addr_o/issue_tag_o = 0.
REQ-034 After reset release, ld_ready_o SHALL be 1 in the first cycle; reset asserted mid-operation SHALL drop all queued loads without issuing them.

Verification
REQ-035 The bench SHALL cover: with allow_load_i = 1, enqueue addr 0x1000 tag 3 -> next cycle issue_valid_o = 1, addr 0x1000, tag 3; with issue_ready_i = 1 -> empty one cycle later.
REQ-036 The bench SHALL cover: with allow_load_i = 0, enqueue 4 loads -> ld_ready_o = 0, occupancy_o = 4, blocked_o = 1, stall_cnt_o rising by 1 per cycle; raising allow_load_i -> the 4 loads issue in order, one per cycle.
REQ-037 The bench SHALL cover: a full queue with simultaneous dequeue and ld_valid_i -> no enqueue that cycle, occupancy_o = 3; the next cycle enqueue is accepted.
REQ-038 The bench SHALL cover: flush_i with 3 entries plus a same-cycle ld_valid_i -> occupancy_o = 0 the next cycle, the new load is dropped, and stall_cnt_o is retained.
REQ-039 The bench SHALL cover: 10 enqueue/dequeue cycles at occupancy 1 -> the pointers wrap, and the tags emerge in order with no false full or empty.
REQ-040 The bench SHALL cover: rst_n low with 2 entries queued -> occupancy_o = 0 and issue_valid_o = 0 immediately, with no issue after release.
